// File: rtl/cve2_wb_pipe_stage_if.sv
// Handshake and data bundle between ID/EX + LSU (master) and the registered
// writeback stage (slave).
interface cve2_wb_pipe_stage_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned PcWidth      = 32
);
    // ID/EX -> WB
    logic                    en_wb_i;
    logic [1:0]              instr_type_wb_i;
    logic [PcWidth-1:0]      pc_id_i;
    logic                    instr_is_compressed_id_i;
    logic                    instr_perf_count_id_i;
    logic [RegAddrWidth-1:0] rf_waddr_id_i;
    logic [DataWidth-1:0]    rf_wdata_id_i;
    logic                    rf_we_id_i;

    // LSU -> WB
    logic [DataWidth-1:0]    rf_wdata_lsu_i;
    logic                    rf_we_lsu_i;
    logic                    lsu_resp_valid_i;
    logic                    lsu_resp_err_i;

    // WB -> ID / register file / performance counters
    logic                    ready_wb_o;
    logic                    rf_write_wb_o;
    logic                    outstanding_load_wb_o;
    logic                    outstanding_store_wb_o;
    logic [PcWidth-1:0]      pc_wb_o;
    logic                    perf_instr_ret_wb_o;
    logic                    perf_instr_ret_compressed_wb_o;
    logic                    perf_instr_ret_wb_spec_o;
    logic                    perf_instr_ret_compressed_wb_spec_o;
    logic [DataWidth-1:0]    rf_wdata_fwd_wb_o;
    logic [RegAddrWidth-1:0] rf_waddr_wb_o;
    logic [DataWidth-1:0]    rf_wdata_wb_o;
    logic                    rf_we_wb_o;
    logic                    instr_done_wb_o;

    modport master (
        output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
        input  ready_wb_o, rf_write_wb_o, outstanding_load_wb_o, outstanding_store_wb_o,
               pc_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o,
               perf_instr_ret_wb_spec_o, perf_instr_ret_compressed_wb_spec_o,
               rf_wdata_fwd_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               instr_done_wb_o
    );

    modport slave (
        input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
               rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
        output ready_wb_o, rf_write_wb_o, outstanding_load_wb_o, outstanding_store_wb_o,
               pc_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o,
               perf_instr_ret_wb_spec_o, perf_instr_ret_compressed_wb_spec_o,
               rf_wdata_fwd_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
               instr_done_wb_o
    );
endinterface

// File: rtl/cve2_wb_pipe_stage.sv
// Registered writeback stage: holds one retired ID/EX instruction, writes its
// result (or the load data) to the register file and drives retire pulses.
module cve2_wb_pipe_stage #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned PcWidth      = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    cve2_wb_pipe_stage_if.slave  wb
);
    localparam logic [1:0] WB_INSTR_LOAD  = 2'b00;
    localparam logic [1:0] WB_INSTR_STORE = 2'b01;
    localparam logic [1:0] WB_INSTR_OTHER = 2'b10;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]              valid_q;
    logic [1:0]              type_q;
    logic [PcWidth-1:0]      pc_q;
    logic [RegAddrWidth-1:0] waddr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic                    we_q;
    logic                    compressed_q;
    logic                    perf_q;

    logic full;
    logic is_load;
    logic is_store;
    logic is_other;
    logic lsu_resp;
    logic lsu_err;
    logic wb_done;
    logic accept;
    logic we_other;
    logic we_load;
    logic [DataWidth-1:0] rf_wdata_mux;

    assign full     = (valid_q == FULL);
    assign is_load  = full & (type_q == WB_INSTR_LOAD);
    assign is_store = full & (type_q == WB_INSTR_STORE);
    assign is_other = full & (type_q == WB_INSTR_OTHER);

    // A response only counts when a memory instruction is actually waiting.
    assign lsu_resp = wb.lsu_resp_valid_i & (is_load | is_store);
    assign lsu_err  = lsu_resp & wb.lsu_resp_err_i;

    assign wb_done = is_other | lsu_resp;
    assign accept  = wb.en_wb_i & wb.ready_wb_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= EMPTY;
            type_q       <= 2'b00;
            pc_q         <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            compressed_q <= 1'b0;
            perf_q       <= 1'b0;
        end else if (accept) begin
            // Retiring and capturing in the same cycle leaves no bubble.
            valid_q      <= FULL;
            type_q       <= wb.instr_type_wb_i;
            pc_q         <= wb.pc_id_i;
            waddr_q      <= wb.rf_waddr_id_i;
            wdata_q      <= wb.rf_wdata_id_i;
            we_q         <= wb.rf_we_id_i;
            compressed_q <= wb.instr_is_compressed_id_i;
            perf_q       <= wb.instr_perf_count_id_i;
        end else if (wb_done) begin
            valid_q      <= EMPTY;
        end
    end

    assign we_other = is_other & we_q;
    // Error responses never write, whatever the LSU requests.
    assign we_load  = is_load & lsu_resp & ~lsu_err & wb.rf_we_lsu_i;

    genvar gi;
    generate
        for (gi = 0; gi < int'(DataWidth); gi++) begin : g_wdata_mux
            assign rf_wdata_mux[gi] = (we_other & wdata_q[gi]) |
                                      (we_load  & wb.rf_wdata_lsu_i[gi]);
        end
    endgenerate

    assign wb.ready_wb_o             = ~full | wb_done;
    assign wb.instr_done_wb_o        = wb_done;
    assign wb.rf_we_wb_o             = we_other | we_load;
    assign wb.rf_wdata_wb_o          = rf_wdata_mux;
    assign wb.rf_waddr_wb_o          = waddr_q;
    assign wb.rf_write_wb_o          = full & (we_q | (type_q == WB_INSTR_LOAD));
    assign wb.rf_wdata_fwd_wb_o      = wdata_q;
    assign wb.outstanding_load_wb_o  = is_load;
    assign wb.outstanding_store_wb_o = is_store;
    assign wb.pc_wb_o                = pc_q;

    assign wb.perf_instr_ret_wb_o                 = wb_done & perf_q & ~lsu_err;
    assign wb.perf_instr_ret_compressed_wb_o      = wb_done & perf_q & ~lsu_err & compressed_q;
    assign wb.perf_instr_ret_wb_spec_o            = full & perf_q & ~wb_done;
    assign wb.perf_instr_ret_compressed_wb_spec_o = full & perf_q & ~wb_done & compressed_q;

    a_no_accept_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wb.en_wb_i && !wb.ready_wb_o));

    a_rf_write_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0({we_other, we_load}));

    a_store_no_we: assert property (@(posedge clk_i) disable iff (rst_i)
        !(is_store && we_q));

    a_no_spurious_resp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wb.lsu_resp_valid_i && !(is_load || is_store)));

endmodule

// File: tb/tb_cve2_wb_pipe_stage.sv
// Scoreboard bench for cve2_wb_pipe_stage: the stimulus pushes the expected
// completion of each instruction, a monitor pops it on every instr_done pulse.
module tb_cve2_wb_pipe_stage;
    localparam logic [1:0] T_LOAD  = 2'b00;
    localparam logic [1:0] T_STORE = 2'b01;
    localparam logic [1:0] T_OTHER = 2'b10;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ret;
        logic        ret_c;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   ret_count = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    cve2_wb_pipe_stage_if #(.DataWidth(32), .RegAddrWidth(5), .PcWidth(32)) wb_if ();

    cve2_wb_pipe_stage #(.DataWidth(32), .RegAddrWidth(5), .PcWidth(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (wb_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [31:0] pc, input logic c,
                         input logic perf, input logic [4:0] addr,
                         input logic [31:0] data, input logic we);
        wb_if.en_wb_i                  = 1'b1;
        wb_if.instr_type_wb_i          = t;
        wb_if.pc_id_i                  = pc;
        wb_if.instr_is_compressed_id_i = c;
        wb_if.instr_perf_count_id_i    = perf;
        wb_if.rf_waddr_id_i            = addr;
        wb_if.rf_wdata_id_i            = data;
        wb_if.rf_we_id_i               = we;
    endtask

    task automatic lsu_resp(input logic err, input logic we, input logic [31:0] data);
        wb_if.lsu_resp_valid_i = 1'b1;
        wb_if.lsu_resp_err_i   = err;
        wb_if.rf_we_lsu_i      = we;
        wb_if.rf_wdata_lsu_i   = data;
    endtask

    task automatic idle_inputs();
        wb_if.en_wb_i          = 1'b0;
        wb_if.lsu_resp_valid_i = 1'b0;
        wb_if.lsu_resp_err_i   = 1'b0;
        wb_if.rf_we_lsu_i      = 1'b0;
        wb_if.rf_wdata_lsu_i   = 32'h0;
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ready"}, {31'h0, wb_if.ready_wb_o}, 32'h1);
        chk({name, "_flags"}, {18'h0, wb_if.rf_write_wb_o, wb_if.outstanding_load_wb_o,
            wb_if.outstanding_store_wb_o, wb_if.perf_instr_ret_wb_o,
            wb_if.perf_instr_ret_compressed_wb_o, wb_if.perf_instr_ret_wb_spec_o,
            wb_if.perf_instr_ret_compressed_wb_spec_o, wb_if.rf_we_wb_o,
            wb_if.instr_done_wb_o, wb_if.rf_waddr_wb_o}, 32'h0);
        chk({name, "_pc"}, wb_if.pc_wb_o, 32'h0);
        chk({name, "_wdata"}, wb_if.rf_wdata_wb_o | wb_if.rf_wdata_fwd_wb_o, 32'h0);
    endtask

    // Monitor: every completion must match the oldest expected record.
    always @(negedge clk_i) begin
        if (!rst_i && wb_if.perf_instr_ret_wb_o) ret_count++;
        if (!rst_i && wb_if.instr_done_wb_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_we",    {31'h0, wb_if.rf_we_wb_o}, {31'h0, e.we});
                chk("rf_waddr", {27'h0, wb_if.rf_waddr_wb_o}, {27'h0, e.waddr});
                chk("rf_wdata", wb_if.rf_wdata_wb_o, e.wdata);
                chk("ret",      {31'h0, wb_if.perf_instr_ret_wb_o}, {31'h0, e.ret});
                chk("ret_c",    {31'h0, wb_if.perf_instr_ret_compressed_wb_o}, {31'h0, e.ret_c});
            end
        end
    end

    initial begin
        int ret_before;
        idle_inputs();
        issue(T_OTHER, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        wb_if.en_wb_i = 1'b0;
        #3;
        chk_idle_outputs("reset");
        step();
        rst_i = 1'b0;
        step();
        chk_idle_outputs("empty");

        // ALU op, one-cycle writeback.
        issue(T_OTHER, 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        exp_q.push_back('{we: 1'b1, waddr: 5'd5, wdata: 32'hDEADBEEF, ret: 1'b1, ret_c: 1'b0});
        step();
        wb_if.en_wb_i = 1'b0;
        chk("alu_pc", wb_if.pc_wb_o, 32'h100);
        chk("alu_fwd", wb_if.rf_wdata_fwd_wb_o, 32'hDEADBEEF);
        chk("alu_rf_write", {31'h0, wb_if.rf_write_wb_o}, 32'h1);
        step();
        chk("alu_empty_done", {31'h0, wb_if.instr_done_wb_o}, 32'h0);
        chk("alu_empty_ready", {31'h0, wb_if.ready_wb_o}, 32'h1);

        // Load answered in the third cycle.
        issue(T_LOAD, 32'h104, 1'b0, 1'b1, 5'd7, 32'h0, 1'b0);
        exp_q.push_back('{we: 1'b1, waddr: 5'd7, wdata: 32'h12345678, ret: 1'b1, ret_c: 1'b0});
        step();
        wb_if.en_wb_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("load_wait_outstanding", {31'h0, wb_if.outstanding_load_wb_o}, 32'h1);
            chk("load_wait_ready", {31'h0, wb_if.ready_wb_o}, 32'h0);
            chk("load_wait_spec", {31'h0, wb_if.perf_instr_ret_wb_spec_o}, 32'h1);
            chk("load_wait_rf_write", {31'h0, wb_if.rf_write_wb_o}, 32'h1);
            if (i == 0) step();
        end
        lsu_resp(1'b0, 1'b1, 32'h12345678);
        #1;
        chk("load_resp_ready", {31'h0, wb_if.ready_wb_o}, 32'h1);
        chk("load_resp_spec", {31'h0, wb_if.perf_instr_ret_wb_spec_o}, 32'h0);
        step();
        idle_inputs();

        // Load with error response: completes, no write, not counted.
        issue(T_LOAD, 32'h108, 1'b0, 1'b1, 5'd9, 32'h0, 1'b0);
        exp_q.push_back('{we: 1'b0, waddr: 5'd9, wdata: 32'h0, ret: 1'b0, ret_c: 1'b0});
        step();
        wb_if.en_wb_i = 1'b0;
        lsu_resp(1'b1, 1'b1, 32'hFFFFFFFF);
        #1;
        chk("load_err_done", {31'h0, wb_if.instr_done_wb_o}, 32'h1);
        step();
        idle_inputs();

        // Store, then an ALU op accepted in the store-response cycle.
        ret_before = ret_count;
        issue(T_STORE, 32'h200, 1'b0, 1'b1, 5'd3, 32'h0, 1'b0);
        exp_q.push_back('{we: 1'b0, waddr: 5'd3, wdata: 32'h0, ret: 1'b1, ret_c: 1'b0});
        step();
        wb_if.en_wb_i = 1'b0;
        chk("store_outstanding", {31'h0, wb_if.outstanding_store_wb_o}, 32'h1);
        chk("store_rf_write", {31'h0, wb_if.rf_write_wb_o}, 32'h0);
        step();
        lsu_resp(1'b0, 1'b0, 32'h0);
        issue(T_OTHER, 32'h204, 1'b0, 1'b1, 5'd10, 32'h0000A5A5, 1'b1);
        exp_q.push_back('{we: 1'b1, waddr: 5'd10, wdata: 32'h0000A5A5, ret: 1'b1, ret_c: 1'b0});
        #1;
        chk("b2b_ready", {31'h0, wb_if.ready_wb_o}, 32'h1);
        step();
        idle_inputs();
        chk("b2b_pc", wb_if.pc_wb_o, 32'h204);
        step();
        chk("b2b_retires", ret_count - ret_before, 2);

        // Compressed ALU op counted by both retire counters.
        issue(T_OTHER, 32'h208, 1'b1, 1'b1, 5'd12, 32'h00001234, 1'b1);
        exp_q.push_back('{we: 1'b1, waddr: 5'd12, wdata: 32'h00001234, ret: 1'b1, ret_c: 1'b1});
        step();
        // Non-counted ALU op without write, accepted back-to-back.
        issue(T_OTHER, 32'h20A, 1'b0, 1'b0, 5'd4, 32'hCAFEF00D, 1'b0);
        exp_q.push_back('{we: 1'b0, waddr: 5'd4, wdata: 32'h0, ret: 1'b0, ret_c: 1'b0});
        step();
        wb_if.en_wb_i = 1'b0;
        chk("nowe_rf_write", {31'h0, wb_if.rf_write_wb_o}, 32'h0);
        step();

        // Reset mid-FULL with an outstanding load clears immediately.
        issue(T_LOAD, 32'h300, 1'b1, 1'b1, 5'd7, 32'h0, 1'b0);
        step();
        wb_if.en_wb_i = 1'b0;
        chk("pre_rst_outstanding", {31'h0, wb_if.outstanding_load_wb_o}, 32'h1);
        chk("pre_rst_spec_c", {31'h0, wb_if.perf_instr_ret_compressed_wb_spec_o}, 32'h1);
        #1;
        rst_i = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        step();
        rst_i = 1'b0;
        step();

        chk("pending_expected", exp_q.size(), 0);
        chk("total_retires", ret_count, 5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
